// File: rtl/execute_unit_pkg.sv
// Shared widths, ALU control bit positions, multiplier FSM encoding and bus layouts
// for the execute stage.
package execute_unit_pkg;

  localparam int ID_EXE_W  = 167;
  localparam int EXE_MEM_W = 154;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic        multiply;
    logic        mthi;
    logic        mtlo;
    logic [11:0] alu_control;
    logic [31:0] alu_operand1;
    logic [31:0] alu_operand2;
    logic [3:0]  mem_control;
    logic [31:0] store_data;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;
  } id_exe_bus_t;

  typedef struct packed {
    logic [3:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;
  } exe_mem_bus_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/execute_unit_if.sv
// Execute-stage handshake and bus bundle: master drives the decode side,
// slave is the execute unit.
interface execute_unit_if;
  logic                                   EXE_valid;
  logic [execute_unit_pkg::ID_EXE_W-1:0]  ID_EXE_bus_r;
  logic                                   MEM_allow_in;
  logic                                   cancel;
  logic                                   EXE_over;
  logic [execute_unit_pkg::EXE_MEM_W-1:0] EXE_MEM_bus;
  logic [4:0]                             EXE_wdest;
  logic [31:0]                            EXE_pc;

  modport master (
    output EXE_valid, ID_EXE_bus_r, MEM_allow_in, cancel,
    input  EXE_over, EXE_MEM_bus, EXE_wdest, EXE_pc
  );
  modport slave (
    input  EXE_valid, ID_EXE_bus_r, MEM_allow_in, cancel,
    output EXE_over, EXE_MEM_bus, EXE_wdest, EXE_pc
  );
endinterface

// File: rtl/execute_unit_mul_iter.sv
// Iterative signed 32x32 multiplier: shift-add on magnitudes, one multiplier bit
// per cycle for 32 cycles, sign applied when the result is captured.
module mul_iter
  import execute_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_cancel,
  input  logic        i_ack,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic [63:0] o_product
);
  mul_state_t  r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [63:0] r_product;
  logic        r_neg;
  logic        r_done;
  logic [63:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
  assign o_done    = r_done;
  assign o_product = r_product;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_mcand   <= 64'd0;
      r_mplier  <= 32'd0;
      r_acc     <= 64'd0;
      r_product <= 64'd0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
    end else if (i_cancel) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_mcand  <= {32'd0, mag32(i_a)};
          r_mplier <= mag32(i_b);
          r_neg    <= i_a[31] ^ i_b[31];
          r_acc    <= 64'd0;
          r_cnt    <= 5'd0;
          r_state  <= S_BUSY;
        end
        S_BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_product <= r_neg ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: if (i_ack) begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/execute_unit.sv
// Execute stage: one-hot ALU, HI/LO moves and signed multiply. Define EXE_MUL_ITER_EN
// for the 33-cycle iterative multiplier; otherwise the product is single-cycle.
module execute_unit
  import execute_unit_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  execute_unit_if.slave bus
);
  id_exe_bus_t  w_in;
  exe_mem_bus_t w_out;
  logic [31:0]  w_a, w_b, w_alu;
  logic [11:0]  w_ctl;
  logic [63:0]  w_product;
  logic         w_mul_over;

  assign w_in  = bus.ID_EXE_bus_r;
  assign w_a   = w_in.alu_operand1;
  assign w_b   = w_in.alu_operand2;
  assign w_ctl = w_in.alu_control;

  // Control is one-hot, so OR-ing the gated results selects at most one.
  always_comb begin
    w_alu = 32'd0;
    if (w_ctl[ALU_ADD])  w_alu = w_alu | (w_a + w_b);
    if (w_ctl[ALU_SUB])  w_alu = w_alu | (w_a - w_b);
    if (w_ctl[ALU_SLT])  w_alu = w_alu | {31'd0, $signed(w_a) < $signed(w_b)};
    if (w_ctl[ALU_SLTU]) w_alu = w_alu | {31'd0, w_a < w_b};
    if (w_ctl[ALU_AND])  w_alu = w_alu | (w_a & w_b);
    if (w_ctl[ALU_NOR])  w_alu = w_alu | ~(w_a | w_b);
    if (w_ctl[ALU_OR])   w_alu = w_alu | (w_a | w_b);
    if (w_ctl[ALU_XOR])  w_alu = w_alu | (w_a ^ w_b);
    if (w_ctl[ALU_SLL])  w_alu = w_alu | (w_b << w_a[4:0]);
    if (w_ctl[ALU_SRL])  w_alu = w_alu | (w_b >> w_a[4:0]);
    if (w_ctl[ALU_SRA])  w_alu = w_alu | 32'($signed(w_b) >>> w_a[4:0]);
    if (w_ctl[ALU_LUI])  w_alu = w_alu | {w_b[15:0], 16'h0};
  end

`ifdef EXE_MUL_ITER_EN
  logic w_mul_done;

  mul_iter u_mul (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (bus.EXE_valid & w_in.multiply),
    .i_cancel  (bus.cancel),
    .i_ack     (bus.MEM_allow_in),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );
  assign w_mul_over = w_mul_done & ~bus.cancel;
`else
  logic w_unused;

  assign w_product  = $signed({{32{w_a[31]}}, w_a}) * $signed({{32{w_b[31]}}, w_b});
  assign w_mul_over = 1'b1;
  assign w_unused   = ^{clk, reset, bus.cancel, bus.MEM_allow_in};
`endif

  always_comb begin
    w_out             = '0;
    w_out.mem_control = w_in.mem_control;
    w_out.store_data  = w_in.store_data;
    w_out.mfhi        = w_in.mfhi;
    w_out.mflo        = w_in.mflo;
    w_out.mtc0        = w_in.mtc0;
    w_out.mfc0        = w_in.mfc0;
    w_out.cp0r_addr   = w_in.cp0r_addr;
    w_out.syscall     = w_in.syscall;
    w_out.eret        = w_in.eret;
    w_out.rf_wen      = w_in.rf_wen;
    w_out.rf_wdest    = w_in.rf_wdest;
    w_out.pc          = w_in.pc;
    w_out.exe_result  = w_alu;
    if (w_in.multiply) begin
      w_out.exe_result = w_product[63:32];
      w_out.lo_result  = w_product[31:0];
      w_out.hi_write   = 1'b1;
      w_out.lo_write   = 1'b1;
    end else if (w_in.mthi) begin
      w_out.exe_result = w_a;
      w_out.hi_write   = 1'b1;
    end else if (w_in.mtlo) begin
      w_out.lo_result  = w_a;
      w_out.lo_write   = 1'b1;
    end
  end

  assign bus.EXE_MEM_bus = w_out;
  assign bus.EXE_over    = bus.EXE_valid & (w_in.multiply ? w_mul_over : 1'b1);
  assign bus.EXE_wdest   = bus.EXE_valid ? w_in.rf_wdest : 5'd0;
  assign bus.EXE_pc      = w_in.pc;
endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 clk  input  1  Single clock; all state updates on rising edge.
REQ-002 reset  input  1  Synchronous, active-high reset.
REQ-003 EXE_valid  input  1  EXE stage holds a valid instruction.
REQ-004 ID_EXE_bus_r  input  167  Registered decode bus {multiply,mthi,mtlo,alu_control[11:0],alu_operand1[31:0],alu_operand2[31:0],mem_control[3:0],store_data[31:0],mfhi,mflo,mtc0,mfc0,cp0r_addr[7:0],syscall,eret,rf_wen,rf_wdest[4:0],pc[31:0]}, MSB first.
REQ-005 MEM_allow_in  input  1  MEM stage accepts the EXE result this cycle.
REQ-006 cancel  input  1  Exception/ERET flush; aborts any in-flight multiply.
REQ-007 EXE_over  output  1  EXE result is complete this cycle.
REQ-008 EXE_MEM_bus  output  154  {mem_control,store_data,exe_result[31:0],lo_result[31:0],hi_write,lo_write,mfhi,mflo,mtc0,mfc0,cp0r_addr,syscall,eret,rf_wen,rf_wdest,pc}, MSB first.
REQ-009 EXE_wdest  output  5  rf_wdest when EXE_valid, else 0, for decode hazard check.
REQ-010 EXE_pc  output  32  pc field of the input bus, for display.

Function
REQ-011 ALU: alu_control one-hot, bit11..bit0 = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui; all-zero control yields ALU result 0.
REQ-012 add/sub wrap at 32 bits; slt signed and sltu unsigned compare, result 0 or 1.
REQ-013 Shifts use alu_operand1[4:0] as amount on alu_operand2; sra sign-fills; lui = {alu_operand2[15:0],16'h0}.
REQ-014 Non-multiply instructions: EXE_over = EXE_valid, same cycle, zero added latency.
REQ-015 MULT: signed 32x32 -> 64; exe_result = product[63:32], lo_result = product[31:0], hi_write = lo_write = 1.
REQ-016 MTHI: exe_result = alu_operand1, hi_write = 1; MTLO: lo_result = alu_operand1, lo_write = 1; otherwise hi_write/lo_write/lo_result = 0 and exe_result = ALU result.
REQ-017 Multiply FSM states IDLE, BUSY, DONE; IDLE->BUSY when EXE_valid & multiply & ~cancel, operands latched that cycle.
REQ-018 BUSY runs 32 iterations (5-bit counter 0..31), one operand bit per cycle on magnitudes, sign applied at completion; BUSY->DONE after count 31.
REQ-019 EXE_over for MULT asserted only in DONE, first 33 cycles after the IDLE->BUSY cycle.
REQ-020 DONE->IDLE when MEM_allow_in; otherwise DONE holds product and EXE_over stable.
REQ-021 cancel in any state forces IDLE next cycle and deasserts EXE_over that cycle; cancel has priority over start.
REQ-022 Operand changes on the bus during BUSY/DONE do not affect the latched product.
REQ-023 Product edge case 0x80000000 * 0x80000000 = 0x4000000000000000 exactly.

Reset
REQ-024 reset: FSM IDLE, counter 0, product/operand registers 0, EXE_over follows REQ-014 combinationally (0 when EXE_valid low).
REQ-025 reset mid-BUSY discards the multiply; no stale EXE_over after reset release.

Configuration
REQ-026 Macro EXE_MUL_ITER_EN defined: iterative multiplier per REQ-017..021.
REQ-027 EXE_MUL_ITER_EN undefined: single-cycle combinational signed product, MULT treated per REQ-014, FSM and counter absent; results bit-identical.

Structure
REQ-028 Shared package holds bus widths (167, 154), alu_control bit indices, and FSM state encodings.
REQ-029 Multiplier is sub-module mul_iter (start, cancel, a, b, done, product[63:0]); ALU stays inline.

Verification
REQ-030 ADDU op1=0xFFFFFFFF op2=2 -> exe_result 0x00000001, EXE_over same cycle, hi_write=lo_write=0.
REQ-031 SRA op1=4 op2=0x80000000 -> 0xF8000000; SLT op1=0xFFFFFFFF op2=1 -> 1; SLTU same -> 0.
REQ-032 MULT 0xFFFFFFFE * 3 -> EXE_over at start+33, exe_result 0xFFFFFFFF, lo_result 0xFFFFFFFA, both writes 1.
REQ-033 MULT done with MEM_allow_in=0 for 5 cycles -> EXE_over and product held, IDLE the cycle after MEM_allow_in=1.
REQ-034 cancel at BUSY count 10 -> EXE_over never asserts, next MULT 7*6 returns lo_result 42, exe_result 0.
REQ-035 EXE_valid=1 rf_wdest=9 -> EXE_wdest 9; EXE_valid=0 -> 0; reset during BUSY -> IDLE, EXE_over 0.
